// File: rtl/logic_unit_arbiter_pkg.sv
// Shared definitions for the two-port arbiter around the bitwise logic unit:
// opcodes, FSM encodings, the default data width and the one-bit lane function.
package logic_unit_arbiter_pkg;

    localparam int WIDTH_DEFAULT = 32;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // All four opcodes are decoded, so there is no illegal-op path.
    function automatic logic logic_lane(input logic [1:0] op, input logic a, input logic b);
        logic r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = ~(a & b);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_unit_arbiter_bitwise_logic_unit.sv
// Purely combinational WIDTH-bit bitwise unit (AND/OR/XOR/NAND); each bit is an
// independent lane, so there is no carry between bits.
module bitwise_logic_unit
    import logic_unit_arbiter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_lane
            assign res[gi] = logic_lane(op, a[gi], b[gi]);
        end
    endgenerate

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit between two requesters.
// IDLE accepts one operation, EXEC computes it, HOLD presents the tagged result.
module logic_unit_arbiter
    import logic_unit_arbiter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             res_valid,
    output logic             res_id,
    output logic [WIDTH-1:0] res_data,
    output logic             res_zero,
    input  logic             res_ready
);

    state_t             state_reg;
    logic               last_grant_reg;
    logic [1:0]         op_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               id_reg;
    logic               res_valid_reg;
    logic               res_id_reg;
    logic [WIDTH-1:0]   res_data_reg;
    logic               res_zero_reg;

    logic [1:0]         valid_vec;
    logic [1:0]         grant_vec;
    logic               grant_id;
    logic [1:0]         sel_op;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic [WIDTH-1:0]   unit_res;

    assign valid_vec = {req1_valid, req0_valid};

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        grant_vec = 2'b00;
        if (!reset && state_reg == S_IDLE) begin
            case (valid_vec)
                2'b01:   grant_vec = 2'b01;
                2'b10:   grant_vec = 2'b10;
                2'b11:   grant_vec = last_grant_reg ? 2'b01 : 2'b10;
                default: grant_vec = 2'b00;
            endcase
        end
    end

    assign req0_ready = grant_vec[0];
    assign req1_ready = grant_vec[1];
    assign grant_id   = grant_vec[1];

    assign sel_op = grant_id ? req1_op : req0_op;
    assign sel_a  = grant_id ? req1_a  : req0_a;
    assign sel_b  = grant_id ? req1_b  : req0_b;

    bitwise_logic_unit #(
        .WIDTH (WIDTH)
    ) u_unit (
        .op  (op_reg),
        .a   (a_reg),
        .b   (b_reg),
        .res (unit_res)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            last_grant_reg <= 1'b1;
            op_reg         <= '0;
            a_reg          <= '0;
            b_reg          <= '0;
            id_reg         <= 1'b0;
            res_valid_reg  <= 1'b0;
            res_id_reg     <= 1'b0;
            res_data_reg   <= '0;
            res_zero_reg   <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (|grant_vec) begin
                        op_reg         <= sel_op;
                        a_reg          <= sel_a;
                        b_reg          <= sel_b;
                        id_reg         <= grant_id;
                        last_grant_reg <= grant_id;
                        state_reg      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    res_data_reg  <= unit_res;
                    res_zero_reg  <= (unit_res == '0);
                    res_id_reg    <= id_reg;
                    res_valid_reg <= 1'b1;
                    state_reg     <= S_HOLD;
                end
                S_HOLD: begin
                    if (res_ready) begin
                        res_valid_reg <= 1'b0;
                        state_reg     <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign res_valid = res_valid_reg;
    assign res_id    = res_id_reg;
    assign res_data  = res_data_reg;
    assign res_zero  = res_zero_reg;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: handshake, opcode sweep, fairness,
// backpressure, operand isolation and reset during a held result.
module tb_logic_unit_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready;
    logic [1:0]  req0_op;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready;
    logic [1:0]  req1_op;
    logic [31:0] req1_a, req1_b;
    logic        res_valid, res_id, res_zero, res_ready;
    logic [31:0] res_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    logic_unit_arbiter #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .res_valid  (res_valid),
        .res_id     (res_id),
        .res_data   (res_data),
        .res_zero   (res_zero),
        .res_ready  (res_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one operation, waits for acceptance and the result, checks it.
    // a_after replaces operand A right after acceptance.
    task automatic run_op(input string tag, input bit who, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] a_after, input logic [31:0] exp);
        bit got;
        int lat;
        got = 0;
        if (who) begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
        else     begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
        for (int i = 0; i < 10; i++) begin
            #1;
            if ((who ? req1_ready : req0_ready) === 1'b1) begin
                got = 1;
                chk({tag, "_other_ready"}, {31'd0, who ? req0_ready : req1_ready}, 32'd0);
                break;
            end
            @(posedge clk);
        end
        chk({tag, "_accept"}, {31'd0, got}, 32'd1);
        @(posedge clk); #1;
        if (who) begin req1_valid = 0; req1_a = a_after; end
        else     begin req0_valid = 0; req0_a = a_after; end
        #1;
        chk({tag, "_exec_ready"}, {30'd0, req1_ready, req0_ready}, 32'd0);
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            if (res_valid === 1'b1) break;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, 32'd1);
        chk({tag, "_id"},   {31'd0, res_id}, {31'd0, who});
        chk({tag, "_data"}, res_data, exp);
        chk({tag, "_zero"}, {31'd0, res_zero}, {31'd0, exp == 32'd0});
        if (res_ready) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [31:0] hold_data;
        logic        hold_id;
        logic [1:0]  grants [4];
        logic [1:0]  ids [4];
        int ng, nr;
        bit both_seen;

        reset = 1; res_ready = 1;
        req0_valid = 1; req0_op = 0; req0_a = 0; req0_b = 0;
        req1_valid = 1; req1_op = 0; req1_a = 0; req1_b = 0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        chk("rst_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_data", res_data, 32'd0);
        chk("rst_id_zero", {30'd0, res_id, res_zero}, 32'd0);
        req0_valid = 0; req1_valid = 0; reset = 0;
        @(posedge clk); #1;

        run_op("single_and", 1'b0, 2'b00, 32'd11, 32'd0, 32'd11, 32'd0);

        run_op("sweep_and",  1'b1, 2'b00, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hF0F0_00FF, 32'h00F0_000F);
        run_op("sweep_or",   1'b1, 2'b01, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hF0F0_00FF, 32'hFFF0_0FFF);
        run_op("sweep_xor",  1'b1, 2'b10, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hF0F0_00FF, 32'hFF00_0FF0);
        run_op("sweep_nand", 1'b1, 2'b11, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hF0F0_00FF, 32'hFF0F_FFF0);

        // Tie: last grant was requester 1, so order must be 0,1,0,1.
        for (int i = 0; i < 4; i++) begin grants[i] = 2'd3; ids[i] = 2'd3; end
        ng = 0; nr = 0; both_seen = 0;
        req0_valid = 1; req0_op = 2'b10; req0_a = 32'h1; req0_b = 32'h3;
        req1_valid = 1; req1_op = 2'b01; req1_a = 32'h4; req1_b = 32'h8;
        #1;
        for (int cyc = 0; cyc < 24; cyc++) begin
            if (req0_ready && req1_ready) both_seen = 1;
            if (req0_ready && ng < 4) begin grants[ng] = 2'd0; ng++; end
            else if (req1_ready && ng < 4) begin grants[ng] = 2'd1; ng++; end
            if (res_valid && nr < 4) begin ids[nr] = {1'b0, res_id}; nr++; end
            @(posedge clk); #1;
            if (ng == 4) begin req0_valid = 0; req1_valid = 0; end
            #1;
        end
        chk("tie_both_ready", {31'd0, both_seen}, 32'd0);
        chk("tie_grant0", grants[0], 32'd0);
        chk("tie_grant1", grants[1], 32'd1);
        chk("tie_grant2", grants[2], 32'd0);
        chk("tie_grant3", grants[3], 32'd1);
        chk("tie_id0", ids[0], 32'd0);
        chk("tie_id1", ids[1], 32'd1);
        chk("tie_id2", ids[2], 32'd0);
        chk("tie_id3", ids[3], 32'd1);

        // Backpressure with requester 1 waiting behind a held result.
        res_ready = 0;
        run_op("bp_first", 1'b0, 2'b01, 32'h0000_00A0, 32'h0000_000B, 32'h0000_00A0, 32'h0000_00AB);
        hold_data = res_data; hold_id = res_id;
        req1_valid = 1; req1_op = 2'b10; req1_a = 32'h0000_FFFF; req1_b = 32'h0000_0F0F;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", {31'd0, res_valid}, 32'd1);
            chk("bp_data", res_data, hold_data);
            chk("bp_id", {31'd0, res_id}, {31'd0, hold_id});
            chk("bp_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        end
        res_ready = 1;
        @(posedge clk); #1;
        chk("bp_released_valid", {31'd0, res_valid}, 32'd0);
        chk("bp_req1_ready", {31'd0, req1_ready}, 32'd1);
        @(posedge clk); #1;
        req1_valid = 0;
        @(posedge clk); #1;
        chk("bp_second_valid", {31'd0, res_valid}, 32'd1);
        chk("bp_second_id", {31'd0, res_id}, 32'd1);
        chk("bp_second_data", res_data, 32'h0000_F0F0);
        @(posedge clk); #1;

        run_op("opchange", 1'b0, 2'b00, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0, 32'h1234_5678);

        // Reset while a result is held; last grant was 0, reset must restore 1.
        res_ready = 0;
        run_op("pre_reset", 1'b0, 2'b10, 32'hA, 32'h5, 32'hA, 32'hF);
        reset = 1; req0_valid = 1; req1_valid = 1;
        #1;
        chk("mid_rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        @(posedge clk); #1;
        reset = 0;
        chk("mid_rst_valid", {31'd0, res_valid}, 32'd0);
        chk("mid_rst_data", res_data, 32'd0);
        chk("mid_rst_id_zero", {30'd0, res_id, res_zero}, 32'd0);
        #1;
        chk("post_rst_tie", {30'd0, req1_ready, req0_ready}, 32'd1);
        req0_valid = 0; req1_valid = 0;
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Shares one 32-bit bitwise logic unit between two requesters.
- Each requester hands over an opcode and two operands through a valid/ready handshake.
- The arbiter picks one requester round-robin, runs the operation through the shared unit, and returns a tagged result on a valid/ready output port.
- Sits between the lab's ALU control logic and the behavioural bitwise datapath. It serialises access so only one copy of the unit is needed.

Parameters:
- WIDTH, 32: operand and result width in bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 presents an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_op  input  2  requester 0 opcode: 00 AND, 01 OR, 10 XOR, 11 NAND.
- req0_a  input  WIDTH  requester 0 operand A.
- req0_b  input  WIDTH  requester 0 operand B.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1.
- res_valid  output  1  result available.
- res_id  output  1  index of the requester that owns the result.
- res_data  output  WIDTH  operation result.
- res_zero  output  1  high when res_data is all zeros.
- res_ready  input  1  consumer accepts the result.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values: state=IDLE, last_grant=1, res_valid=0, res_id=0, res_data=0, res_zero=0. Latched op/a/b registers are cleared to 0. reqN_ready is 0 while reset is high.
- FSM states: IDLE, EXEC, HOLD.
- IDLE:
  - reqN_ready is a combinational function of reqN_valid, state and last_grant.
  - If exactly one valid is high, that requester gets ready=1.
  - If both are high, the requester not equal to last_grant gets ready=1 and the other gets 0.
  - Never more than one ready high in any cycle.
  - On the accepting edge: latch op, a, b and id; set last_grant=id; go to EXEC.
  - No valid high: stay in IDLE.
- EXEC (exactly 1 cycle):
  - The shared unit evaluates the latched op/a/b.
  - On the edge: res_data <= result, res_zero <= (result==0), res_id <= latched id, res_valid <= 1; go to HOLD.
  - Both reqN_ready are 0.
- HOLD:
  - res_valid=1. res_data, res_id and res_zero stay stable until res_ready is sampled high.
  - When res_ready=1: res_valid <= 0 and go to IDLE.
  - While in HOLD, both reqN_ready are 0.
- Latency and throughput:
  - Accept at edge N gives res_valid high after edge N+1, and the result is visible in cycle N+2.
  - Maximum throughput is one operation per 3 cycles when res_ready is tied high.
- Requester obligations: a requester holds valid/op/a/b stable until it sees ready. Operands that change after acceptance have no effect on the result.
- Fairness: under continuous requests from both sides, grants strictly alternate 0,1,0,1… The first tie after reset goes to requester 0.
- Reset mid-operation:
  - Any in-flight operation in EXEC or HOLD is discarded with no result emitted.
  - All outputs return to their reset values on that edge.
  - last_grant returns to 1.
- Width rules: all operations are bitwise on WIDTH bits, with no carry or overflow. NAND is ~(a&b) over the full width.
- Invalid opcode: none exists, because the 2-bit op is fully decoded.

Decomposition:
- Shared package/header holds:
  - opcode constants OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NAND=2'b11;
  - state encodings S_IDLE, S_EXEC, S_HOLD;
  - WIDTH default 32.
- One natural sub-module, bitwise_logic_unit: purely combinational, with inputs op, a, b and output res. It is instantiated once inside the arbiter. The arbiter holds the FSM, grant pointer, operand latches and result register.

Test Plan:
- Single AND: req0_valid=1, op=00, a=11, b=0; res_ready=1 → req0_ready high for 1 cycle; two cycles later res_valid=1, res_id=0, res_data=0, res_zero=1.
- Opcode sweep on requester 1: a=32'hF0F0_00FF, b=32'h0FF0_0F0F:
  - AND → 32'h00F0_000F;
  - OR → 32'hFFF0_0FFF;
  - XOR → 32'hFF00_0FF0;
  - NAND → 32'hFF0F_FFF0.
  - For every result: res_id=1 and res_zero=0.
- Tie and fairness: both valid held high for 4 operations, res_ready=1 → grant order 0,1,0,1; ready is never high on both ports in the same cycle; res_id follows the same sequence.
- Backpressure: result pending, res_ready=0 for 5 cycles → res_valid, res_data and res_id stable; both reqN_ready=0; req1_valid held high is accepted only after res_ready=1 returns the FSM to IDLE.
- Operand change after accept: req0 a=32'hFFFF_FFFF, b=32'h1234_5678 with AND; a changed to 0 the cycle after ready → res_data=32'h1234_5678.
- Reset mid-HOLD: assert reset for 1 cycle while res_valid=1 → next cycle res_valid=0, res_data=0, state IDLE; a following tie grants requester 0 first.
